// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared state encoding and PC constants for the instruction fetch unit
package ifu_pkg;

    // FETCH: request outstanding, FULL: buffer holds an instruction, DRAIN: discard in-flight response
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_FULL  = 2'd1,
        ST_DRAIN = 2'd2
    } ifu_state_t;

    // Matches the IF/ID register reset value so a freshly reset IF stage looks like a bubble
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/ifu_perf_counters.sv
// rtl/ifu_perf_counters.sv - two saturating event counters (stall and flush) for the fetch unit
module ifu_perf_counters #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Count events, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - IF stage: PC, imem req/ready fetch, one-entry buffer, branch redirect; IFU_PERF_CNT_EN adds perf counters
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef IFU_PERF_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr_out,
    output logic [31:0]      pc_out,
    output logic             le_ifid
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    ifu_state_t  state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] redirect_pc;

    assign redirect_pc = align_pc(branch_target);

    // A request is outstanding in FETCH and DRAIN; reset suppresses it so memory sees nothing that cycle
    assign imem_req  = (state != ST_FULL) & ~reset;
    assign imem_addr = req_addr;

    // The buffer is handed to ID only when ID can take it and no redirect is killing it
    assign le_ifid   = (state == ST_FULL) & ~stall & ~branch_taken;

    // Fetch FSM with PC, request address and holding buffer; redirect outranks every other event
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            instr_out <= NOP_INSTR;
            pc_out    <= RESET_PC;
        end else if (branch_taken) begin
            pc <= redirect_pc;
            case (state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        // Response lands this cycle and is dropped; start the target fetch at once
                        req_addr <= redirect_pc;
                        state    <= ST_FETCH;
                    end else begin
                        // Memory still owes a word for the old address; wait it out
                        state <= ST_DRAIN;
                    end
                end
                ST_FULL: begin
                    req_addr <= redirect_pc;
                    state    <= ST_FETCH;
                end
                ST_DRAIN: begin
                    if (imem_ready) begin
                        req_addr <= redirect_pc;
                        state    <= ST_FETCH;
                    end else begin
                        state <= ST_DRAIN;
                    end
                end
                default: begin
                    req_addr <= redirect_pc;
                    state    <= ST_FETCH;
                end
            endcase
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        instr_out <= imem_rdata;
                        pc_out    <= req_addr;
                        pc        <= pc + PC_STEP;
                        state     <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // Stall keeps the buffer and its outputs frozen until ID consumes it
                    if (!stall) begin
                        req_addr <= pc;
                        state    <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    // Stale response is discarded; refetch from the (possibly redirected) pc
                    if (imem_ready) begin
                        req_addr <= pc;
                        state    <= ST_FETCH;
                    end
                end
                default: begin
                    req_addr <= pc;
                    state    <= ST_FETCH;
                end
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic stall_event;
    logic flush_event;

    assign stall_event = (state == ST_FULL) & stall & ~branch_taken;
    assign flush_event = branch_taken;

    ifu_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk       (clk),
        .reset     (reset),
        .stall_inc (stall_event),
        .flush_inc (flush_event),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit (IFU_PERF_CNT_EN checks counters when defined)
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        le_ifid;
`ifdef IFU_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    // second instance for the wrap-around reset PC
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic [31:0] instr_out2;
    logic [31:0] pc_out2;
    logic        le_ifid2;
    logic        br2 = 1'b0;
    logic [31:0] bt2 = 32'h0;
    logic        st2 = 1'b0;
`ifdef IFU_PERF_CNT_EN
    logic [15:0] stall_cnt2;
    logic [15:0] flush_cnt2;
`endif

    int vectors = 0;
    int fails   = 0;

    // memory model: ready in the mem_lat-th cycle of each request, data tagged with address
    logic        mem_ready   = 1'b0;
    logic        force_ready = 1'b0;
    logic [31:0] mem_rdata   = 32'h0;
    int          mem_lat     = 1;
    int          mem_cnt     = 0;

    assign imem_ready = mem_ready | force_ready;
    assign imem_rdata = mem_rdata;

    always @(negedge clk) begin
        if (imem_req) begin
            mem_cnt   = mem_ready ? 1 : mem_cnt + 1;
            mem_ready = (mem_cnt >= mem_lat);
            mem_rdata = imem_addr ^ 32'hA500_0000;
        end else begin
            mem_cnt   = 0;
            mem_ready = 1'b0;
        end
    end

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .le_ifid       (le_ifid)
`ifdef IFU_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    instr_fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8)
    ) dut2 (
        .clk           (clk),
        .reset         (reset),
        .stall         (st2),
        .branch_taken  (br2),
        .branch_target (bt2),
        .imem_req      (imem_req2),
        .imem_addr     (imem_addr2),
        .imem_ready    (imem_req2),
        .imem_rdata    (~imem_addr2),
        .instr_out     (instr_out2),
        .pc_out        (pc_out2),
        .le_ifid       (le_ifid2)
`ifdef IFU_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt2),
        .flush_cnt     (flush_cnt2)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: every le_ifid pulse must match the oldest expected delivery
    always @(negedge clk) begin
        if (le_ifid) begin
            vectors++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_delivery: got pc %h instr %h expected none", pc_out, instr_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (pc_out !== e.pc || instr_out !== e.instr) begin
                    fails++;
                    $display("FAIL delivery: got pc %h instr %h expected pc %h instr %h",
                             pc_out, instr_out, e.pc, e.instr);
                end
            end
        end
    end

    // wrap-around instance: first three deliveries checked against hand values
    logic [31:0] exp2_pc [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    logic [31:0] exp2_in [3] = '{32'h0000_0007, 32'h0000_0003, 32'hFFFF_FFFF};
    int          n2 = 0;

    always @(negedge clk) begin
        if (le_ifid2 && n2 < 3) begin
            vectors++;
            if (pc_out2 !== exp2_pc[n2] || instr_out2 !== exp2_in[n2]) begin
                fails++;
                $display("FAIL wrap_delivery%0d: got pc %h instr %h expected pc %h instr %h",
                         n2, pc_out2, instr_out2, exp2_pc[n2], exp2_in[n2]);
            end
            n2++;
        end
    end

    logic le_tab [13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                          1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          1'b1, 1'b0, 1'b1};

    initial begin
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;

        tick();
        @(negedge clk);
        check("rst_imem_req", {31'h0, imem_req}, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_instr_out", instr_out, 32'h0);
        check("rst_le_ifid", {31'h0, le_ifid}, 32'h0);
`ifdef IFU_PERF_CNT_EN
        check("rst_stall_cnt", {16'h0, stall_cnt}, 32'h0);
        check("rst_flush_cnt", {16'h0, flush_cnt}, 32'h0);
`endif

        // streaming at 1-cycle latency, with a 5-cycle stall while FULL at pc 8
        sb.push_back('{32'h0000_0000, 32'hA500_0000});
        sb.push_back('{32'h0000_0004, 32'hA500_0004});
        sb.push_back('{32'h0000_0008, 32'hA500_0008});
        sb.push_back('{32'h0000_000C, 32'hA500_000C});
        tick();
        reset = 1'b0;
        for (int n = 0; n < 13; n++) begin
            stall = (n >= 5 && n <= 9);
            @(negedge clk);
            check($sformatf("le_ifid_c%0d", n), {31'h0, le_ifid}, {31'h0, le_tab[n]});
            if (stall) begin
                check($sformatf("stall_instr_c%0d", n), instr_out, 32'hA500_0008);
                check($sformatf("stall_pc_c%0d", n), pc_out, 32'h0000_0008);
                check($sformatf("stall_req_c%0d", n), {31'h0, imem_req}, 32'h0);
            end
`ifdef IFU_PERF_CNT_EN
            if (n == 10) check("stall_cnt", {16'h0, stall_cnt}, 32'd5);
`endif
            tick();
        end

        // branch to 0x103 while a 3-cycle fetch of 0x10 is in flight
        mem_lat = 3;
        sb.push_back('{32'h0000_0100, 32'hA500_0100});
        @(negedge clk);
        check("fetch10_addr", imem_addr, 32'h0000_0010);
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        @(negedge clk);
        check("branch_le_ifid", {31'h0, le_ifid}, 32'h0);
        tick();
        branch_taken = 1'b0;
        @(negedge clk);
        check("drain_req", {31'h0, imem_req}, 32'h1);
        check("drain_addr", imem_addr, 32'h0000_0010);
`ifdef IFU_PERF_CNT_EN
        check("flush_cnt1", {16'h0, flush_cnt}, 32'd1);
`endif
        tick();
        @(negedge clk);
        check("redirect_addr", imem_addr, 32'h0000_0100);
        check("redirect_req", {31'h0, imem_req}, 32'h1);

        // two redirects inside one DRAIN: only the latest target is fetched
        repeat (4) tick();
        sb.push_back('{32'h0000_0300, 32'hA500_0300});
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0200;
        @(negedge clk);
        check("fetch104_addr", imem_addr, 32'h0000_0104);
        tick();
        branch_target = 32'h0000_0300;
        @(negedge clk);
        check("drain2_addr", imem_addr, 32'h0000_0104);
        tick();
        branch_taken = 1'b0;
        @(negedge clk);
`ifdef IFU_PERF_CNT_EN
        check("flush_cnt3", {16'h0, flush_cnt}, 32'd3);
`endif
        tick();
        @(negedge clk);
        check("latest_target_addr", imem_addr, 32'h0000_0300);
        repeat (4) tick();

        // reset in the same cycle as branch_taken and imem_ready
        reset         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0500;
        force_ready   = 1'b1;
        @(negedge clk);
        check("rst2_req_low", {31'h0, imem_req}, 32'h0);
        tick();
        reset        = 1'b0;
        branch_taken = 1'b0;
        force_ready  = 1'b0;
        sb.push_back('{32'h0000_0000, 32'hA500_0000});
        @(negedge clk);
        check("rst2_addr", imem_addr, 32'h0000_0000);
        check("rst2_pc_out", pc_out, 32'h0000_0000);
        check("rst2_instr_out", instr_out, 32'h0000_0000);
        check("rst2_le_ifid", {31'h0, le_ifid}, 32'h0);
`ifdef IFU_PERF_CNT_EN
        check("rst2_flush_cnt", {16'h0, flush_cnt}, 32'h0);
`endif
        repeat (6) tick();

        check("scoreboard_pending", sb.size(), 32'd0);
        check("wrap_deliveries", n2, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
